sorted_stream_drain: RTL and testbench

- Downstream neighbour of the sorter. Captures the sorted-memory write stream (SM_valid/SM_addr/SM_data) into a local ELEMENT_NUM-deep buffer.
- Checks that the stream is ascending and sequentially addressed.
- Once the buffer is full, drains the elements in order over a valid/ready output handshake to the next consumer.
- Runs in the minor clock domain (clk_mn).

---
 rtl/sorted_stream_drain.sv | 94 +++++++++
 tb/tb_sorted_stream_drain.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_stream_drain.sv
// sorted_stream_drain: captures one sorted batch from the sorter write stream, flags ordering/addressing/overrun
// problems, then drains the batch in index order over a valid/ready handshake.
module sorted_stream_drain #(
  parameter int DATA_WIDTH       = 8,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4
) (
  input  logic                        clk_mn,
  input  logic                        rst,
  input  logic                        SM_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  input  logic [DATA_WIDTH-1:0]       SM_data,
  input  logic                        restart,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [LOG2_ELEMENT_NUM-1:0] out_idx,
  output logic                        full,
  output logic                        drain_done,
  output logic                        order_err,
  output logic                        addr_err,
  output logic                        overrun_err
);
  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;
  localparam logic [LOG2_ELEMENT_NUM-1:0] LAST = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);
  state_t state, state_nx;
  logic [LOG2_ELEMENT_NUM-1:0] wr_cnt, wr_cnt_nx, rd_idx, rd_idx_nx;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] mem [ELEMENT_NUM];
  logic order_nx, addr_nx, overrun_nx, we;
  // restart outranks everything: a coincident write or handshake is simply dropped
  always_comb begin
    state_nx   = state;
    wr_cnt_nx  = wr_cnt;
    rd_idx_nx  = rd_idx;
    order_nx   = order_err;
    addr_nx    = addr_err;
    overrun_nx = overrun_err;
    we         = 1'b0;
    if (restart) begin
      state_nx   = FILL;
      wr_cnt_nx  = '0;
      rd_idx_nx  = '0;
      order_nx   = 1'b0;
      addr_nx    = 1'b0;
      overrun_nx = 1'b0;
    end else if (state == FILL) begin
      if (SM_valid) begin
        we        = 1'b1;
        order_nx  = order_err | (wr_cnt != '0 && SM_data < prev);
        addr_nx   = addr_err | (SM_addr != wr_cnt);
        wr_cnt_nx = wr_cnt == LAST ? '0 : wr_cnt + 1'b1;
        state_nx  = wr_cnt == LAST ? DRAIN : FILL;
      end
    end else begin
      overrun_nx = overrun_err | SM_valid;
      if (state == DRAIN && out_ready) begin
        rd_idx_nx = rd_idx == LAST ? '0 : rd_idx + 1'b1;
        state_nx  = rd_idx == LAST ? DONE : DRAIN;
      end
    end
  end
  // status outputs are registered from the next state so they track the FSM with no decode delay
  always_ff @(posedge clk_mn or negedge rst) begin
    if (!rst) begin
      state       <= FILL;
      wr_cnt      <= '0;
      rd_idx      <= '0;
      prev        <= '0;
      out_valid   <= 1'b0;
      full        <= 1'b0;
      drain_done  <= 1'b0;
      order_err   <= 1'b0;
      addr_err    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_cnt      <= wr_cnt_nx;
      rd_idx      <= rd_idx_nx;
      prev        <= we ? SM_data : prev;
      out_valid   <= state_nx == DRAIN;
      full        <= state_nx == DRAIN;
      drain_done  <= state_nx == DONE;
      order_err   <= order_nx;
      addr_err    <= addr_nx;
      overrun_err <= overrun_nx;
    end
  end
  always_ff @(posedge clk_mn) begin
    if (we) mem[wr_cnt] <= SM_data;
  end
  assign out_data = mem[rd_idx];
  assign out_idx  = rd_idx;
endmodule

// File: tb/tb_sorted_stream_drain.sv
// tb_sorted_stream_drain: randomized batches checked against a queue/array model of the batch buffer.
module tb_sorted_stream_drain;
  localparam int W = 8;
  localparam int E = 8;
  localparam int L = 3;
  logic clk_mn = 1'b0, rst = 1'b0, SM_valid = 1'b0, restart = 1'b0, out_ready = 1'b0;
  logic [L-1:0] SM_addr = '0;
  logic [W-1:0] SM_data = '0;
  logic out_valid, full, drain_done, order_err, addr_err, overrun_err;
  logic [W-1:0] out_data;
  logic [L-1:0] out_idx;
  int checks = 0, failures = 0;
  logic [W-1:0] dq [E];
  logic [L-1:0] aq [E];
  logic log_o [E], log_a [E], log_f [E];

  sorted_stream_drain #(.DATA_WIDTH(W), .ELEMENT_NUM(E), .LOG2_ELEMENT_NUM(L)) dut (
    .clk_mn(clk_mn), .rst(rst), .SM_valid(SM_valid), .SM_addr(SM_addr), .SM_data(SM_data),
    .restart(restart), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .full(full), .drain_done(drain_done), .order_err(order_err),
    .addr_err(addr_err), .overrun_err(overrun_err)
  );

  always #5 clk_mn = ~clk_mn;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic seq_addr();
    for (int i = 0; i < E; i++) aq[i] = L'(i);
  endtask

  task automatic gen_sorted();
    int v;
    v = $urandom_range(0, 40);
    for (int i = 0; i < E; i++) begin
      dq[i] = W'(v);
      v = v + $urandom_range(0, 30);
      if (v > 255) v = 255;
    end
  endtask

  task automatic fill(input bit gaps);
    for (int i = 0; i < E; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk_mn);
        SM_valid = 1'b0;
      end
      @(negedge clk_mn);
      log_o[i] = order_err;
      log_a[i] = addr_err;
      log_f[i] = full;
      SM_valid = 1'b1;
      SM_addr  = aq[i];
      SM_data  = dq[i];
    end
    @(negedge clk_mn);
    SM_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({out_valid, full, drain_done, order_err, addr_err, overrun_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_state: got %b want 000000", {out_valid, full, drain_done, order_err, addr_err, overrun_err});
    end
    @(negedge clk_mn);
    rst = 1'b1;
  endtask

  // mode[1:0]: 0 ready always, 1 ready 1,0,0 pattern, 2 random ready; mode[2]: idle gaps; mode[3]: skip restart
  task automatic test_batch(input string name, input int mode);
    logic eo, ea, po, pa, rdy;
    int got, cyc;
    if (mode[3] == 1'b0) begin
      @(negedge clk_mn);
      restart = 1'b1;
      @(negedge clk_mn);
      restart = 1'b0;
      checks++;
      if ({out_valid, full, drain_done, order_err, addr_err, overrun_err} !== 6'b0) begin
        failures++;
        $display("FAIL %s restart_state: got %b want 000000", name, {out_valid, full, drain_done, order_err, addr_err, overrun_err});
      end
    end
    eo = 1'b0;
    ea = 1'b0;
    for (int i = 0; i < E; i++) begin
      if (i > 0 && dq[i] < dq[i-1]) eo = 1'b1;
      if (aq[i] != L'(i)) ea = 1'b1;
    end
    fill(mode[2]);
    checks++;
    if (log_f[E-1] !== 1'b0) begin
      failures++;
      $display("FAIL %s early_full: full=%b before last beat, want 0", name, log_f[E-1]);
    end
    po = 1'b0;
    pa = 1'b0;
    for (int i = 0; i < E; i++) begin
      checks++;
      if ({log_o[i], log_a[i]} !== {po, pa}) begin
        failures++;
        $display("FAIL %s err_timing beat%0d: order/addr=%b%b want %b%b", name, i, log_o[i], log_a[i], po, pa);
      end
      if (i > 0 && dq[i] < dq[i-1]) po = 1'b1;
      if (aq[i] != L'(i)) pa = 1'b1;
    end
    checks++;
    if ({full, out_valid, drain_done} !== 3'b110) begin
      failures++;
      $display("FAIL %s full_latency: full/valid/done=%b want 110", name, {full, out_valid, drain_done});
    end
    checks++;
    if ({order_err, addr_err, overrun_err} !== {eo, ea, 1'b0}) begin
      failures++;
      $display("FAIL %s errs_after_fill: got %b want %b", name, {order_err, addr_err, overrun_err}, {eo, ea, 1'b0});
    end
    got = 0;
    cyc = 0;
    while (got < E && cyc < 200) begin
      checks++;
      if ({out_valid, out_idx, out_data} !== {1'b1, L'(got), dq[got]}) begin
        failures++;
        $display("FAIL %s drain cyc%0d: valid/idx/data=%b/%0d/%0d want 1/%0d/%0d", name, cyc, out_valid, out_idx, out_data, got, dq[got]);
      end
      rdy = mode[1:0] == 0 ? 1'b1 : mode[1:0] == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      @(negedge clk_mn);
      if (rdy) got++;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (got != E) begin
      failures++;
      $display("FAIL %s drain_timeout: accepted %0d want %0d", name, got, E);
    end
    checks++;
    if ({drain_done, out_valid, full, order_err, addr_err, overrun_err} !== {3'b100, eo, ea, 1'b0}) begin
      failures++;
      $display("FAIL %s done_state: got %b want %b", name, {drain_done, out_valid, full, order_err, addr_err, overrun_err}, {3'b100, eo, ea, 1'b0});
    end
    repeat (3) @(negedge clk_mn);
    checks++;
    if ({drain_done, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s done_hold: done/valid=%b want 10", name, {drain_done, out_valid});
    end
  endtask

  task automatic test_overrun_restart();
    @(negedge clk_mn);
    restart = 1'b1;
    @(negedge clk_mn);
    restart = 1'b0;
    gen_sorted();
    seq_addr();
    fill(1'b0);
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b1;
      @(negedge clk_mn);
    end
    out_ready = 1'b0;
    SM_valid = 1'b1;
    SM_addr  = '0;
    SM_data  = 8'hAA;
    @(negedge clk_mn);
    SM_valid = 1'b0;
    checks++;
    if ({overrun_err, order_err, addr_err} !== 3'b100) begin
      failures++;
      $display("FAIL overrun_flag: overrun/order/addr=%b want 100", {overrun_err, order_err, addr_err});
    end
    for (int k = 2; k < 4; k++) begin
      checks++;
      if ({out_valid, out_idx, out_data} !== {1'b1, L'(k), dq[k]}) begin
        failures++;
        $display("FAIL overrun_drain idx%0d: valid/idx/data=%b/%0d/%0d want 1/%0d/%0d", k, out_valid, out_idx, out_data, k, dq[k]);
      end
      out_ready = 1'b1;
      @(negedge clk_mn);
    end
    restart  = 1'b1;
    SM_valid = 1'b1;
    SM_data  = 8'h01;
    @(negedge clk_mn);
    restart   = 1'b0;
    SM_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, full, drain_done, order_err, addr_err, overrun_err} !== 6'b0) begin
      failures++;
      $display("FAIL restart_clear: got %b want 000000", {out_valid, full, drain_done, order_err, addr_err, overrun_err});
    end
    gen_sorted();
    test_batch("after_restart", 8);
  endtask

  task automatic test_async_reset();
    @(negedge clk_mn);
    restart = 1'b1;
    @(negedge clk_mn);
    restart = 1'b0;
    dq = '{50, 10, 60, 70, 80, 90, 100, 110};
    seq_addr();
    aq[2] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_mn);
      SM_valid = 1'b1;
      SM_addr  = aq[i];
      SM_data  = dq[i];
    end
    @(negedge clk_mn);
    SM_valid = 1'b0;
    checks++;
    if ({order_err, addr_err} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset_errs: order/addr=%b want 11", {order_err, addr_err});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, full, drain_done, order_err, addr_err, overrun_err} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset: got %b want 000000", {out_valid, full, drain_done, order_err, addr_err, overrun_err});
    end
    @(negedge clk_mn);
    rst = 1'b1;
    gen_sorted();
    seq_addr();
    test_batch("post_async_reset", 8);
  endtask

  initial begin
    test_reset();
    dq = '{3, 5, 5, 9, 12, 40, 41, 200};
    seq_addr();
    test_batch("basic", 0);
    test_batch("backpressure", 1);
    dq = '{10, 20, 15, 30, 40, 50, 60, 70};
    test_batch("order", 0);
    dq = '{1, 2, 3, 4, 5, 6, 7, 8};
    aq = '{0, 1, 2, 7, 4, 5, 6, 7};
    test_batch("addr", 1);
    test_overrun_restart();
    test_async_reset();
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) gen_sorted();
      else for (int i = 0; i < E; i++) dq[i] = W'($urandom_range(0, 255));
      seq_addr();
      if (r == 5) aq[$urandom_range(0, E-1)] = L'($urandom_range(0, E-1));
      test_batch("random", 4 | (r % 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
